// File: rtl/riscv_fetch_pkg.sv
// ----------------------------------------------------------------------------
// riscv_fetch_pkg
// Shared constants and types for the instruction-fetch front end.
//   PC_INC        : byte distance between consecutive instruction words
//   PC_ALIGN_MASK : low PC bits that are forced to zero on a redirect
//   NOP_INSTR     : canonical RV32 NOP (addi x0,x0,0); the fetch unit never
//                   presents it by itself, so benches can tell a reset head
//                   (all zeros) apart from a real instruction
//   req_state_e   : request-hold state of the memory request port
// ----------------------------------------------------------------------------
package riscv_fetch_pkg;

  localparam int unsigned PC_INC        = 4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'h0000_0003;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  // REQ_HOLD means a request was offered last cycle but not accepted, so it
  // must be offered again unchanged regardless of enable.
  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_HOLD = 1'b1
  } req_state_e;

endpackage

// File: rtl/riscv_sync_fifo.sv
// ----------------------------------------------------------------------------
// riscv_sync_fifo
// Single-clock FIFO used as the prefetch queue. The head entry is read
// straight out of the storage registers, so there is no write-to-read bypass:
// an entry pushed at edge N is visible at the head only after edge N.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (empties the queue)
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the queue; wins over push and pop in the same cycle
//   head_data  : current head entry (undefined content when empty)
//   count      : number of valid entries
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module riscv_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is only legal when the head leaves in the same
  // cycle; an empty queue has no head to pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// ----------------------------------------------------------------------------
// riscv_fetch_unit
// Instruction-fetch front end: owns the fetch PC, issues word-aligned requests
// to instruction memory, queues in-order responses with their PCs and hands
// them to decode. A redirect flushes the queue and discards every response
// still in flight.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   enable                          : allow new fetch requests
//   redirect_valid, redirect_pc     : one-cycle branch/jump redirect strobe
//   imem_req_valid/addr/ready       : request channel to instruction memory
//   imem_rsp_valid/data             : in-order response channel
//   instr_valid/data/pc, instr_ready: queue head towards decode
// ----------------------------------------------------------------------------
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  localparam int              CW           = $clog2(DEPTH+1);
  localparam int              EW           = XLEN + ILEN;
  localparam logic [XLEN-1:0] PC_STEP      = XLEN'(PC_INC);
  localparam logic [XLEN-1:0] PC_KEEP      = ~XLEN'(PC_ALIGN_MASK);
  localparam logic [CW:0]     CREDIT_LIMIT = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_next;
  logic [CW-1:0]   q_count;
  logic            credit;
  logic            handshake;
  logic            rsp_drop;
  logic            q_push;
  logic            q_pop;
  logic            q_full;
  logic            q_empty;
  logic [EW-1:0]   q_head;
  req_state_e      req_state;
  req_state_e      req_state_next;

  assign redirect_target = redirect_pc & PC_KEEP;

  // Queued plus in-flight words never exceed the queue size, so every
  // response that is kept always finds a free slot.
  assign credit = ({1'b0, q_count} + {1'b0, outstanding}) < CREDIT_LIMIT;

  // Request port: a request that was offered but not taken stays offered
  // with the same address (fetch_pc only moves on a handshake). Only a
  // redirect withdraws it; the redirect cycle itself never issues.
  always_comb begin
    req_state_next = req_state;
    imem_req_valid = 1'b0;
    if (!redirect_valid) begin
      imem_req_valid = (req_state == REQ_HOLD) || (enable && credit);
    end
    if (redirect_valid) begin
      req_state_next = REQ_IDLE;
    end else if (imem_req_valid && !imem_req_ready) begin
      req_state_next = REQ_HOLD;
    end else begin
      req_state_next = REQ_IDLE;
    end
  end

  assign imem_req_addr = fetch_pc;
  assign handshake     = imem_req_valid & imem_req_ready;

  // A response is thrown away while older redirects still owe drops, and
  // also when it coincides with a redirect (it belongs to the old path).
  assign rsp_drop = imem_rsp_valid & (redirect_valid | (drop_cnt != '0));
  assign q_push   = imem_rsp_valid & ~rsp_drop;
  assign q_pop    = instr_valid & instr_ready & ~redirect_valid;

  // After a redirect every request still in flight belongs to the old path,
  // so the drop count becomes the new outstanding count. This already
  // includes drops owed by earlier redirects, which makes back-to-back
  // redirects accumulate correctly.
  always_comb begin
    outstanding_next = outstanding;
    drop_next        = drop_cnt;
    if (redirect_valid) begin
      outstanding_next = outstanding - CW'(imem_rsp_valid);
      drop_next        = outstanding_next;
    end else begin
      outstanding_next = outstanding + CW'(handshake) - CW'(imem_rsp_valid);
      drop_next        = drop_cnt - CW'(rsp_drop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_state   <= REQ_IDLE;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      req_state   <= req_state_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
      end else begin
        if (handshake) fetch_pc <= fetch_pc + PC_STEP;
        if (q_push)    rsp_pc   <= rsp_pc + PC_STEP;
      end
    end
  end

  riscv_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head_data (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // With an empty queue the head shows zero data and the PC the next kept
  // response will carry (RESET_PC straight out of reset).
  assign instr_valid = ~q_empty;
  assign instr_data  = instr_valid ? q_head[ILEN-1:0] : '0;
  assign instr_pc    = instr_valid ? q_head[EW-1:ILEN] : rsp_pc;

`ifndef SYNTHESIS
  rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != '0));
  push_has_room: assert property (@(posedge clk) disable iff (rst)
    q_push |-> (!q_full || q_pop));
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_riscv_fetch_unit
// Bench for riscv_fetch_unit (DEPTH=4, RESET_PC=FFFF_FFF8 so the PC wraps).
// Part 1 applies hand-computed cycle tables; part 2 drives random traffic
// against a memory model and an epoch-based reference of the fetch stream.
// ----------------------------------------------------------------------------
module tb_riscv_fetch_unit;

  localparam int          XLEN  = 32;
  localparam int          ILEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RP    = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  riscv_fetch_unit #(
    .XLEN (XLEN), .ILEN (ILEN), .DEPTH (DEPTH), .RESET_PC (RP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- table-driven part ----------------
  typedef struct {
    logic        rst, en, rdy, rsp;
    logic [31:0] rdata;
    logic        ir, redir;
    logic [31:0] rpc;
    logic        rv;
    logic [31:0] raddr;
    logic        iv;
    logic [31:0] ipc, idata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rs, input logic en, input logic rdy, input logic rsp, input logic [31:0] rdata,
    input logic ir, input logic redir, input logic [31:0] rpc,
    input logic rv, input logic [31:0] raddr, input logic iv, input logic [31:0] ipc,
    input logic [31:0] idata);
    vec_t v;
    v.rst = rs; v.en = en; v.rdy = rdy; v.rsp = rsp; v.rdata = rdata;
    v.ir = ir; v.redir = redir; v.rpc = rpc;
    v.rv = rv; v.raddr = raddr; v.iv = iv; v.ipc = ipc; v.idata = idata;
    return v;
  endfunction

  // ---------------- random part: memory and reference model ----------------
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] mq[$];
  logic [31:0] m_fetch;
  bit          m_hold;
  int          m_epoch;
  int          cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F17;
  endfunction

  initial begin
    localparam logic [31:0] D0 = 32'h1111_0001, D1 = 32'h2222_0002, D2 = 32'h3333_0003;
    localparam logic [31:0] D3 = 32'h4444_0004, D4 = 32'h5555_0005, D5 = 32'h6666_0006;
    localparam logic [31:0] D6 = 32'h7777_0007, E0 = 32'hDEAD_0000, E1 = 32'hDEAD_0001;
    localparam logic [31:0] E2 = 32'hDEAD_0002, G0 = 32'hA0A0_0100, G1 = 32'hA0A0_0104;

    // streaming from reset with PC wrap, enable drop, held request, redirect
    tbl.push_back(mk(1,0,0,0,0 ,0,0,0,      0,RP,          0,RP,          0));
    tbl.push_back(mk(0,1,1,0,0 ,1,0,0,      1,32'hFFFF_FFF8,0,0,          0));
    tbl.push_back(mk(0,1,1,1,D0,1,0,0,      1,32'hFFFF_FFFC,0,0,          0));
    tbl.push_back(mk(0,1,1,1,D1,1,0,0,      1,32'h0000_0000,1,32'hFFFF_FFF8,D0));
    tbl.push_back(mk(0,1,1,1,D2,1,0,0,      1,32'h0000_0004,1,32'hFFFF_FFFC,D1));
    tbl.push_back(mk(0,0,1,1,D3,1,0,0,      0,0,           1,32'h0000_0000,D2));
    tbl.push_back(mk(0,1,0,0,0 ,0,0,0,      1,32'h0000_0008,1,32'h0000_0004,D3));
    tbl.push_back(mk(0,0,0,0,0 ,0,0,0,      1,32'h0000_0008,1,32'h0000_0004,D3));
    tbl.push_back(mk(0,0,1,0,0 ,1,0,0,      1,32'h0000_0008,1,32'h0000_0004,D3));
    tbl.push_back(mk(0,0,1,1,D4,1,0,0,      0,0,           0,0,           0));
    tbl.push_back(mk(0,0,0,0,0 ,0,0,0,      0,0,           1,32'h0000_0008,D4));
    tbl.push_back(mk(0,1,1,0,0 ,1,1,32'h103,0,0,           1,32'h0000_0008,D4));
    tbl.push_back(mk(0,1,1,0,0 ,1,0,0,      1,32'h0000_0100,0,0,          0));
    tbl.push_back(mk(0,1,1,1,D5,1,0,0,      1,32'h0000_0104,0,0,          0));
    tbl.push_back(mk(0,0,0,0,0 ,1,0,0,      0,0,           1,32'h0000_0100,D5));
    tbl.push_back(mk(0,0,0,1,D6,1,0,0,      0,0,           0,0,           0));
    tbl.push_back(mk(0,0,0,0,0 ,0,0,0,      0,0,           1,32'h0000_0104,D6));
    // reset with a non-empty queue, then redirect with 3 in flight and a
    // response arriving in the redirect cycle
    tbl.push_back(mk(1,0,0,0,0 ,0,0,0,      0,RP,          0,RP,          0));
    tbl.push_back(mk(0,1,1,0,0 ,1,0,0,      1,32'hFFFF_FFF8,0,0,          0));
    tbl.push_back(mk(0,1,1,0,0 ,1,0,0,      1,32'hFFFF_FFFC,0,0,          0));
    tbl.push_back(mk(0,1,1,0,0 ,1,0,0,      1,32'h0000_0000,0,0,          0));
    tbl.push_back(mk(0,1,1,1,E0,1,1,32'h103,0,0,           0,0,           0));
    tbl.push_back(mk(0,1,1,1,E1,1,0,0,      1,32'h0000_0100,0,0,          0));
    tbl.push_back(mk(0,1,0,1,E2,1,0,0,      1,32'h0000_0104,0,0,          0));
    tbl.push_back(mk(0,1,0,1,G0,1,0,0,      1,32'h0000_0104,0,0,          0));
    tbl.push_back(mk(0,0,1,0,0 ,0,0,0,      1,32'h0000_0104,1,32'h0000_0100,G0));
    tbl.push_back(mk(0,0,1,1,G1,0,0,0,      0,0,           1,32'h0000_0100,G0));
    tbl.push_back(mk(0,0,0,0,0 ,1,0,0,      0,0,           1,32'h0000_0100,G0));
    tbl.push_back(mk(0,0,0,0,0 ,1,0,0,      0,0,           1,32'h0000_0104,G1));
    tbl.push_back(mk(0,0,0,0,0 ,0,0,0,      0,0,           0,0,           0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst            = tbl[i].rst;
      enable         = tbl[i].en;
      imem_req_ready = tbl[i].rdy;
      imem_rsp_valid = tbl[i].rsp;
      imem_rsp_data  = tbl[i].rdata;
      instr_ready    = tbl[i].ir;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      #1;
      chk($sformatf("tbl%0d req_valid", i), 32'(imem_req_valid), 32'(tbl[i].rv));
      if (tbl[i].rv || tbl[i].rst)
        chk($sformatf("tbl%0d req_addr", i), imem_req_addr, tbl[i].raddr);
      chk($sformatf("tbl%0d instr_valid", i), 32'(instr_valid), 32'(tbl[i].iv));
      if (tbl[i].iv || tbl[i].rst) begin
        chk($sformatf("tbl%0d instr_pc", i), instr_pc, tbl[i].ipc);
        chk($sformatf("tbl%0d instr_data", i), instr_data, tbl[i].idata);
      end
    end

    // random traffic; the model tracks the path epoch of every request
    m_fetch = RP; m_hold = 0; m_epoch = 0; cyc = 0;
    @(negedge clk);
    rst = 1'b1; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4000; k++) begin
      int  ph, p_en, p_rdy, p_ir, p_rsp, p_red, lat_lo, lat_hi;
      bit  exp_rv, exp_iv, hs, pop, rspv;
      ph = (k / 500) % 4;
      case (ph)
        0:       begin p_en = 100; p_rdy = 100; p_ir = 100; p_rsp = 100; p_red = 0;  lat_lo = 1; lat_hi = 1; end
        1:       begin p_en = 90;  p_rdy = 80;  p_ir = 10;  p_rsp = 90;  p_red = 1;  lat_lo = 1; lat_hi = 2; end
        2:       begin p_en = 70;  p_rdy = 60;  p_ir = 60;  p_rsp = 70;  p_red = 5;  lat_lo = 1; lat_hi = 4; end
        default: begin p_en = 80;  p_rdy = 70;  p_ir = 70;  p_rsp = 80;  p_red = 15; lat_lo = 2; lat_hi = 3; end
      endcase
      if (k != 0) @(negedge clk);
      if (k == 2100) begin
        rst = 1'b1; enable = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0; instr_ready = 1'b0;
        #1;
        chk("rnd_rst req_valid", 32'(imem_req_valid), 32'd0);
        chk("rnd_rst instr_valid", 32'(instr_valid), 32'd0);
        chk("rnd_rst instr_pc", instr_pc, RP);
        chk("rnd_rst instr_data", instr_data, 32'd0);
        chk("rnd_rst req_addr", imem_req_addr, RP);
        @(posedge clk);
        pend.delete(); mq.delete(); m_fetch = RP; m_hold = 0; m_epoch++; cyc++;
        continue;
      end
      rst            = 1'b0;
      enable         = ($urandom_range(99) < p_en);
      imem_req_ready = ($urandom_range(99) < p_rdy);
      instr_ready    = ($urandom_range(99) < p_ir);
      redirect_valid = ($urandom_range(99) < p_red);
      redirect_pc    = $urandom();
      rspv = (pend.size() > 0) && (pend.size() == 0 ? 1'b0 : pend[0].due <= cyc)
             && ($urandom_range(99) < p_rsp);
      imem_rsp_valid = rspv;
      imem_rsp_data  = rspv ? mem_word(pend[0].addr) : $urandom();
      #1;
      exp_rv = !redirect_valid && (m_hold || (enable && (pend.size() + mq.size() < DEPTH)));
      exp_iv = (mq.size() != 0);
      chk($sformatf("rnd%0d req_valid", k), 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk($sformatf("rnd%0d req_addr", k), imem_req_addr, m_fetch);
      chk($sformatf("rnd%0d instr_valid", k), 32'(instr_valid), 32'(exp_iv));
      if (exp_iv) begin
        chk($sformatf("rnd%0d instr_pc", k), instr_pc, mq[0]);
        chk($sformatf("rnd%0d instr_data", k), instr_data, mem_word(mq[0]));
      end
      hs  = exp_rv && imem_req_ready;
      pop = exp_iv && instr_ready;
      @(posedge clk);
      if (rspv) begin
        req_t r;
        r = pend.pop_front();
        if (redirect_valid) begin
          // coincides with a redirect: old path, discarded
        end else if (r.epoch == m_epoch) begin
          if (pop) void'(mq.pop_front());
          pop = 0;
          mq.push_back(r.addr);
        end
      end
      if (redirect_valid) begin
        mq.delete();
        m_epoch++;
        m_fetch = {redirect_pc[31:2], 2'b00};
        m_hold  = 0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (hs) begin
          req_t n;
          n.addr = m_fetch; n.epoch = m_epoch; n.due = cyc + $urandom_range(lat_hi, lat_lo);
          pend.push_back(n);
          m_fetch = m_fetch + 32'd4;
        end
        m_hold = exp_rv && !imem_req_ready;
      end
      cyc++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
